// File: rtl/signal_capture_bram.sv
// signal_capture_bram: captures 2**NB_ADDR signed samples into an inferred block RAM
// and serves registered random-access reads once the capture is not running.
module signal_capture_bram #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 10
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic signed [NB_DATA-1:0] i_data,
  input  logic                      i_start,
  input  logic                      i_rd_req,
  input  logic        [NB_ADDR-1:0] i_rd_addr,
  output logic signed [NB_DATA-1:0] o_rd_data,
  output logic                      o_rd_valid,
  output logic                      o_busy,
  output logic                      o_done,
  output logic        [NB_ADDR:0]   o_count
);
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  state_t                    r_state;
  logic [NB_ADDR-1:0]        r_wr_ptr;
  logic [NB_ADDR:0]          r_count;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_rd_valid;
  logic signed [NB_DATA-1:0] r_rd_data;
  logic signed [NB_DATA-1:0] r_mem [2**NB_ADDR];
  logic                      w_wr_en;
  logic                      w_rd_en;
  logic                      w_last;
  assign w_wr_en = (r_state == CAPTURE) && i_valid;
  assign w_rd_en = (r_state != CAPTURE) && i_rd_req;
  assign w_last  = &r_wr_ptr;
  // no reset on the array so it maps onto block RAM
  always_ff @(posedge i_clock)
    if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_en;
      if (w_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE:
          if (i_start) begin
            r_state  <= CAPTURE;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end
        CAPTURE:
          if (i_valid) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count  <= r_count + 1'b1;
            if (w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        default: r_state <= IDLE;
      endcase
    end
  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_count    = r_count;
endmodule

// File: tb/tb_signal_capture_bram.sv
// tb_signal_capture_bram: random and directed stimulus checked every cycle against a
// behavioural model of the capture buffer, plus literal spot checks.
module tb_signal_capture_bram;
  localparam int DEPTH = 1024;
  logic       clk = 0, rst = 1;
  logic       valid = 0, start = 0, rd_req = 0;
  logic [7:0] data = 0;
  logic [9:0] rd_addr = 0;
  logic [7:0] rd_data;
  logic       rd_valid, busy, done;
  logic [10:0] count;
  int errors = 0, checks = 0, busy_cycles = 0;

  signal_capture_bram dut (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_data(data), .i_start(start),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_busy(busy), .o_done(done), .o_count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // model: phase 0 idle, 1 capturing, 2 full buffer held; samples land at index = count
  int         m_phase = 0, m_cnt = 0;
  logic [7:0] m_mem [DEPTH];
  bit         m_known [DEPTH];
  logic [7:0] m_rd = 0;
  bit         m_rdv = 0, m_rd_chk = 1;

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_rd = 0; m_rdv = 0; m_rd_chk = 1;
    end else begin
      m_rdv = rd_req && m_phase != 1;
      if (m_rdv) begin
        m_rd = m_mem[rd_addr];
        m_rd_chk = m_known[rd_addr];
      end
      if (m_phase == 1) begin
        if (valid) begin
          m_mem[m_cnt] = data;
          m_known[m_cnt] = 1;
          m_cnt++;
          if (m_cnt == DEPTH) m_phase = 2;
        end
      end else if (start) begin
        m_phase = 1;
        m_cnt = 0;
      end
    end

  always @(negedge clk)
    if (!rst) begin
      busy_cycles += int'(busy);
      chk("busy", int'(busy), int'(m_phase == 1));
      chk("done", int'(done), int'(m_phase == 2));
      chk("count", int'(count), m_cnt);
      chk("rd_valid", int'(rd_valid), int'(m_rdv));
      if (m_rd_chk) chk("rd_data", int'(rd_data), int'(m_rd));
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic mid_reset();
    #2 rst = 1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    tick(); tick();
    rst = 0;
  endtask

  task automatic read_lit(input int a, input int e);
    rd_req = 1; rd_addr = 10'(a); tick(); rd_req = 0;
    chk("lit_rd_valid", int'(rd_valid), 1);
    chk("lit_rd_data", int'(rd_data), e);
  endtask

  initial begin
    tick(); tick(); rst = 0; tick();
    mid_reset();
    // full capture of an address ramp
    busy_cycles = 0;
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      valid = 1; data = 8'(i); tick();
    end
    valid = 0;
    chk("full_done", int'(done), 1);
    chk("full_count", int'(count), 1024);
    tick();
    chk("full_busy_cycles", busy_cycles, 1024);
    read_lit(0, 8'h00);
    read_lit(5, 8'h05);
    read_lit(1023, 8'hFF);
    tick();
    chk("rd_valid_drop", int'(rd_valid), 0);
    // gapped input, with reads attempted mid-capture
    pulse_start();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      valid = (i % 2 == 0); data = 8'($urandom);
      rd_req = (i > 100 && i < 120); rd_addr = 10'($urandom);
      tick();
      if (i == 99) chk("gap_count_mid", int'(count), 50);
      if (i == 110) chk("gap_rd_blocked", int'(rd_valid), 0);
    end
    valid = 0; rd_req = 0;
    chk("gap_done", int'(done), 1);
    for (int i = 0; i < 64; i++) begin
      rd_req = 1; rd_addr = 10'($urandom); tick();
    end
    rd_req = 0;
    // abort after 300 samples, then restart from address 0
    pulse_start();
    for (int i = 0; i < 300; i++) begin
      valid = 1; data = 8'($urandom); tick();
    end
    chk("abort_pre_count", int'(count), 300);
    mid_reset();
    valid = 0;
    chk("abort_done", int'(done), 0);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      valid = 1; data = 8'hA0 + 8'(i); tick();
    end
    chk("restart_count", int'(count), 5);
    for (int i = 5; i < DEPTH; i++) begin
      data = 8'($urandom); tick();
    end
    valid = 0;
    read_lit(0, 8'hA0);
    read_lit(4, 8'hA4);
    // recapture from DONE with a read in the same cycle as start
    rd_req = 1; rd_addr = 10'd3; start = 1; tick(); start = 0; rd_req = 0;
    chk("recap_rd_valid", int'(rd_valid), 1);
    chk("recap_rd_data", int'(rd_data), 8'hA3);
    chk("recap_done_drop", int'(done), 0);
    for (int i = 0; i < DEPTH; i++) begin
      valid = 1; data = 8'hFF; start = (i == 500); tick();
    end
    valid = 0; start = 0;
    chk("recap_done", int'(done), 1);
    for (int i = 0; i < 4; i++) read_lit(int'($urandom_range(0, DEPTH - 1)), 8'hFF);
    // random traffic
    for (int i = 0; i < 6000; i++) begin
      valid = ($urandom_range(0, 9) < 7); data = 8'($urandom);
      start = ($urandom_range(0, 199) == 0); rd_req = $urandom_range(0, 1) == 1;
      rd_addr = 10'($urandom);
      tick();
    end
    start = 0; valid = 0; rd_req = 0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
